// File: rtl/cpu_pkg.sv
// Shared types for the multicycle RISC sequencer: FSM states, IR field codes,
// datapath select encodings and instruction classes. STEP_WAIT exists only with SEQ_SINGLE_STEP_EN.
package cpu_pkg;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_SHIFT = 2'b00;
  localparam logic [1:0] MOV_IMM   = 2'b10;

  typedef enum logic [4:0] {
    S_RST,
    S_FETCH1,
    S_FETCH2,
    S_UPD_PC,
    S_DECODE,
    S_WB_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_EXEC_A0,
    S_WB,
    S_CMP,
    S_ADD_IMM,
    S_LD_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_GET_RD,
    S_PASS_B,
    S_MEM_WR,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_e;

  typedef enum logic [1:0] {
    RS_RM = 2'b00,
    RS_RD = 2'b01,
    RS_RN = 2'b10
  } reg_sel_e;

  typedef enum logic [1:0] {
    WB_C      = 2'b00,
    WB_PC     = 2'b01,
    WB_SXIMM8 = 2'b10,
    WB_MDATA  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [3:0] {
    I_MOVI,
    I_MOVR,
    I_ALU,
    I_MVN,
    I_CMP,
    I_LDR,
    I_STR,
    I_HALT,
    I_NOP
  } iclass_e;

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational instruction classifier: maps IR opcode/ALU_op to the path the sequencer follows.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] alu_op,
  output iclass_e    iclass
);

  always_comb begin
    iclass = I_NOP;
    case (opcode)
      OPC_MOV: begin
        if (alu_op == MOV_IMM)        iclass = I_MOVI;
        else if (alu_op == MOV_SHIFT) iclass = I_MOVR;
      end
      OPC_ALU: begin
        case (alu_op)
          ALU_ADD, ALU_AND: iclass = I_ALU;
          ALU_CMP:          iclass = I_CMP;
          ALU_MVN:          iclass = I_MVN;
          default:          iclass = I_NOP;
        endcase
      end
      OPC_LDR:  if (alu_op == ALU_ADD) iclass = I_LDR;
      OPC_STR:  if (alu_op == ALU_ADD) iclass = I_STR;
      OPC_HALT: iclass = I_HALT;
      default:  iclass = I_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Moore fetch/decode/execute sequencer for the simple RISC datapath and 1-cycle RAM.
// Optional single-step gate before each fetch: define SEQ_SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
  output logic       waiting,
`endif
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       sel_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  // Only the strobes for the PC/address registers live here; the width is checked for sanity.
  if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
    $error("cpu_sequencer: ADDR_W must be in 1..16");
  end

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_e S_ENTRY = S_STEP_WAIT;
`else
  localparam state_e S_ENTRY = S_FETCH1;
`endif

  state_e  state_q, state_d;
  iclass_e iclass;

  instr_class_decode u_decode (
    .opcode (opcode),
    .alu_op (ALU_op),
    .iclass (iclass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_RST;
    reg_sel   = RS_RM;
    wb_sel    = WB_C;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    load_pc   = 1'b0;
    clear_pc  = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    sel_addr  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    waiting   = 1'b0;
`endif

    case (state_q)
      S_RST: begin
        load_pc  = 1'b1;
        clear_pc = 1'b1;
        state_d  = S_ENTRY;
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        waiting = 1'b1;
        state_d = step ? S_FETCH1 : S_STEP_WAIT;
      end
`endif
      S_FETCH1: begin
        sel_addr = 1'b1;
        mem_cmd  = MEM_READ;
        state_d  = S_FETCH2;
      end
      S_FETCH2: begin
        sel_addr = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
        state_d  = S_UPD_PC;
      end
      S_UPD_PC: begin
        load_pc = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          I_MOVI:                      state_d = S_WB_IMM;
          I_MOVR, I_MVN:               state_d = S_GET_B;
          I_ALU, I_CMP, I_LDR, I_STR:  state_d = S_GET_A;
          I_HALT:                      state_d = S_HALT;
          default:                     state_d = S_ENTRY;
        endcase
      end
      S_WB_IMM: begin
        reg_sel = RS_RN;
        wb_sel  = WB_SXIMM8;
        w_en    = 1'b1;
        state_d = S_ENTRY;
      end
      S_GET_A: begin
        reg_sel = RS_RN;
        en_A    = 1'b1;
        state_d = (iclass == I_LDR || iclass == I_STR) ? S_ADD_IMM : S_GET_B;
      end
      S_GET_B: begin
        reg_sel = RS_RM;
        en_B    = 1'b1;
        if (iclass == I_CMP)                           state_d = S_CMP;
        else if (iclass == I_MOVR || iclass == I_MVN)  state_d = S_EXEC_A0;
        else                                           state_d = S_EXEC;
      end
      S_EXEC: begin
        en_C    = 1'b1;
        state_d = S_WB;
      end
      // Single-operand ops get their own execute state so sel_A stays a pure function of state.
      S_EXEC_A0: begin
        sel_A   = 1'b1;
        en_C    = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        reg_sel = RS_RD;
        wb_sel  = WB_C;
        w_en    = 1'b1;
        state_d = S_ENTRY;
      end
      S_CMP: begin
        en_status = 1'b1;
        state_d   = S_ENTRY;
      end
      S_ADD_IMM: begin
        sel_B   = 1'b1;
        en_C    = 1'b1;
        state_d = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        load_addr = 1'b1;
        state_d   = (iclass == I_LDR) ? S_MEM_RD : S_GET_RD;
      end
      S_MEM_RD: begin
        mem_cmd = MEM_READ;
        state_d = S_MEM_WB;
      end
      // Read data is valid one cycle after the request, so the read stays asserted here.
      S_MEM_WB: begin
        mem_cmd = MEM_READ;
        reg_sel = RS_RD;
        wb_sel  = WB_MDATA;
        w_en    = 1'b1;
        state_d = S_ENTRY;
      end
      S_GET_RD: begin
        reg_sel = RS_RD;
        en_B    = 1'b1;
        state_d = S_PASS_B;
      end
      S_PASS_B: begin
        sel_A   = 1'b1;
        en_C    = 1'b1;
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd = MEM_WRITE;
        state_d = S_ENTRY;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule
